// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset pulse, lock filter, staggered domain reset release; ports clki, rst, locked -> pll_rst, domain_rst, ready, lock_loss_count, retry_count; define PLL_SUP_RETRY_EN for lock-timeout retries
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS   = 2,
  parameter int PLLRST_CYCLES = 16,
  parameter int LOCK_FILTER   = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STAGGER       = 64,
  parameter int CNT_W         = 8
) (
  input  logic                   clki,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       lock_loss_count,
  output logic [CNT_W-1:0]       retry_count
);
  localparam int REL = (NUM_DOMAINS - 1) * STAGGER;
  localparam int PW  = $clog2(PLLRST_CYCLES);
  localparam int FW  = $clog2(LOCK_FILTER);
  localparam int RW  = REL < 2 ? 1 : $clog2(REL + 1);
  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, FILTER, RELEASE, RUN} state_t;
  state_t state, state_n;
  logic sync1, locked_s, lost;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic pll_rst_n, ready_n;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic [CNT_W-1:0] lock_loss_n;
`ifdef PLL_SUP_RETRY_EN
  localparam int TW = $clog2(LOCK_TIMEOUT);
  logic [TW-1:0] tcnt, tcnt_n;
  logic [CNT_W-1:0] retry_n;
`endif
  assign lost = (state == RELEASE || state == RUN) && !locked_s;
  always_comb begin
    state_n      = state;
    pcnt_n       = pcnt;
    fcnt_n       = fcnt;
    rcnt_n       = rcnt;
    pll_rst_n    = pll_rst;
    domain_rst_n = domain_rst;
    ready_n      = ready;
    lock_loss_n  = lock_loss_count;
`ifdef PLL_SUP_RETRY_EN
    tcnt_n       = tcnt;
    retry_n      = retry_count;
`endif
    if (lost) begin
      state_n      = PLL_RESET;
      pcnt_n       = '0;
      pll_rst_n    = 1'b1;
      domain_rst_n = '1;
      ready_n      = 1'b0;
      lock_loss_n  = &lock_loss_count ? lock_loss_count : lock_loss_count + CNT_W'(1);
    end else begin
      case (state)
        PLL_RESET: begin
`ifdef PLL_SUP_RETRY_EN
          tcnt_n = '0;
`endif
          if (pcnt == PW'(PLLRST_CYCLES - 1)) begin
            state_n   = WAIT_LOCK;
            pll_rst_n = 1'b0;
          end else begin
            pcnt_n = pcnt + PW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = FILTER;
            fcnt_n  = '0;
`ifdef PLL_SUP_RETRY_EN
            tcnt_n  = '0;
          end else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            state_n   = PLL_RESET;
            pcnt_n    = '0;
            pll_rst_n = 1'b1;
            retry_n   = &retry_count ? retry_count : retry_count + CNT_W'(1);
          end else begin
            tcnt_n = tcnt + TW'(1);
`endif
          end
        end
        FILTER: begin
          if (!locked_s) begin
            state_n = WAIT_LOCK;
            fcnt_n  = '0;
`ifdef PLL_SUP_RETRY_EN
            tcnt_n  = '0;
`endif
          end else if (fcnt == FW'(LOCK_FILTER - 1)) begin
            state_n = RELEASE;
            rcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
        RELEASE: begin
          if (rcnt == RW'(REL)) begin
            state_n = RUN;
            ready_n = 1'b1;
          end else begin
            rcnt_n = rcnt + RW'(1);
          end
        end
        RUN: ;
        default: begin
          state_n      = PLL_RESET;
          pcnt_n       = '0;
          pll_rst_n    = 1'b1;
          domain_rst_n = '1;
          ready_n      = 1'b0;
        end
      endcase
      for (int i = 0; i < NUM_DOMAINS; i++)
        if (state_n == RELEASE && 32'(rcnt_n) >= i * STAGGER) domain_rst_n[i] = 1'b0;
    end
  end
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sync1           <= 1'b0;
      locked_s        <= 1'b0;
      state           <= PLL_RESET;
      pcnt            <= '0;
      fcnt            <= '0;
      rcnt            <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      sync1           <= locked;
      locked_s        <= sync1;
      state           <= state_n;
      pcnt            <= pcnt_n;
      fcnt            <= fcnt_n;
      rcnt            <= rcnt_n;
      pll_rst         <= pll_rst_n;
      domain_rst      <= domain_rst_n;
      ready           <= ready_n;
      lock_loss_count <= lock_loss_n;
    end
  end
`ifdef PLL_SUP_RETRY_EN
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      retry_count <= '0;
    end else begin
      tcnt        <= tcnt_n;
      retry_count <= retry_n;
    end
  end
`else
  assign retry_count = '0;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: timed-expectation scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;
  localparam int N = 3, P = 4, F = 8, T = 32, S = 3, W = 4;
  logic clki = 1'b0, rst = 1'b1, locked = 1'b0;
  logic pll_rst, ready;
  logic [N-1:0] domain_rst;
  logic [W-1:0] lock_loss_count, retry_count;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {int at; string tag; int sel; int val;} exp_t;
  exp_t q[$];
  pll_lock_supervisor #(
    .NUM_DOMAINS(N), .PLLRST_CYCLES(P), .LOCK_FILTER(F),
    .LOCK_TIMEOUT(T), .STAGGER(S), .CNT_W(W)
  ) dut (
    .clki(clki), .rst(rst), .locked(locked), .pll_rst(pll_rst),
    .domain_rst(domain_rst), .ready(ready),
    .lock_loss_count(lock_loss_count), .retry_count(retry_count)
  );
  always #5 clki = ~clki;
  always @(posedge clki) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(pll_rst);
      1: return 32'(domain_rst);
      2: return 32'(ready);
      3: return 32'(lock_loss_count);
      default: return 32'(retry_count);
    endcase
  endfunction
  function automatic void expect_at(input int at, input string tag, input int sel, input int val);
    int i = 0;
    exp_t e;
    e = '{at, tag, sel, val};
    while (i < q.size() && q[i].at <= at) i++;
    q.insert(i, e);
  endfunction
  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      check(e.tag, obs(e.sel), 32'(e.val));
    end
  endtask
  always @(negedge clki) drain();
  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clki);
  endtask
  task automatic expect_start(input int l);
    expect_at(l + 10, "filter_hold", 1, 7);
    expect_at(l + 11, "rel_d0", 1, 6);
    expect_at(l + 13, "rel_d1_early", 1, 6);
    expect_at(l + 14, "rel_d1", 1, 4);
    expect_at(l + 16, "rel_d2_early", 1, 4);
    expect_at(l + 17, "rel_d2", 1, 0);
    expect_at(l + 17, "ready_early", 2, 0);
    expect_at(l + 18, "ready", 2, 1);
  endtask
  task automatic expect_loss(input int d, input int n);
    expect_at(d + 2, "loss_pre_ready", 2, 1);
    expect_at(d + 3, "loss_dom", 1, 7);
    expect_at(d + 3, "loss_ready", 2, 0);
    expect_at(d + 3, "loss_cnt", 3, n);
    expect_at(d + 3, "loss_pll_hi", 0, 1);
    expect_at(d + 6, "loss_pll_hold", 0, 1);
    expect_at(d + 7, "loss_pll_lo", 0, 0);
  endtask
  initial begin
    int r0, l, d, g, a, z;
    expect_at(2, "rst_pll", 0, 1);
    expect_at(2, "rst_dom", 1, 7);
    expect_at(2, "rst_ready", 2, 0);
    expect_at(2, "rst_loss", 3, 0);
    expect_at(2, "rst_retry", 4, 0);
    wait_cycle(4);
    r0 = cyc;
    rst = 1'b0;
    expect_at(r0 + 3, "por_pll_hi", 0, 1);
    expect_at(r0 + 4, "por_pll_lo", 0, 0);
    expect_at(r0 + 9, "wait_dom", 1, 7);
    l = r0 + 10;
    wait_cycle(l);
    locked = 1'b1;
    expect_start(l);
    d = l + 22;
    wait_cycle(d);
    locked = 1'b0;
    expect_loss(d, 1);
    g = d + 10;
    wait_cycle(g);
    locked = 1'b1;
    expect_at(g + 11, "glitch_hold", 1, 7);
    expect_start(g + 6);
    wait_cycle(g + 5);
    locked = 1'b0;
    wait_cycle(g + 6);
    locked = 1'b1;
    d = g + 26;
    wait_cycle(d);
    locked = 1'b0;
    expect_loss(d, 2);
    a = d + 10;
    wait_cycle(a);
    locked = 1'b1;
    expect_at(a + 11, "pre_arst_d0", 1, 6);
    expect_at(a + 12, "pre_arst_d1", 1, 6);
    wait_cycle(a + 12);
    #2;
    rst = 1'b1;
    locked = 1'b0;
    #1;
    expect_at(cyc, "arst_dom", 1, 7);
    expect_at(cyc, "arst_pll", 0, 1);
    expect_at(cyc, "arst_ready", 2, 0);
    expect_at(cyc, "arst_loss", 3, 0);
    drain();
    wait_cycle(a + 15);
    r0 = cyc;
    rst = 1'b0;
    expect_at(r0 + 3, "rearm_pll_hi", 0, 1);
    expect_at(r0 + 4, "rearm_pll_lo", 0, 0);
    a = r0 + 10;
    for (int k = 1; k <= 20; k++) begin
      wait_cycle(a);
      locked = 1'b1;
      expect_at(a + 11, "sat_rel", 1, 6);
      wait_cycle(a + 12);
      locked = 1'b0;
      expect_at(a + 15, "sat_cnt", 3, k > 15 ? 15 : k);
      expect_at(a + 15, "sat_dom", 1, 7);
      a += 20;
    end
    z = a - 5;
    expect_at(z + 100, "sat_hold", 3, 15);
    for (int r = 1; r <= 17; r++) begin
`ifdef PLL_SUP_RETRY_EN
      expect_at(z + 36 * r - 1, "retry_pre", 0, 0);
      expect_at(z + 36 * r, "retry_pll", 0, 1);
      expect_at(z + 36 * r, "retry_cnt", 4, r > 15 ? 15 : r);
      expect_at(z + 36 * r + 3, "retry_pll_hold", 0, 1);
      expect_at(z + 36 * r + 4, "retry_pll_lo", 0, 0);
`else
      expect_at(z + 36 * r, "no_retry_pll", 0, 0);
      expect_at(z + 36 * r, "no_retry_cnt", 4, 0);
`endif
    end
    wait_cycle(z + 36 * 17 + 6);
    check("leftover", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2: count of downstream reset domains, range 1-8.
REQ-002 SHALL have parameter PLLRST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse, minimum 2.
REQ-003 SHALL have parameter LOCK_FILTER, default 1024: consecutive synchronised-lock cycles required before release, minimum 2.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles before a retry, minimum 4.
REQ-005 SHALL have parameter STAGGER, default 64: cycles between successive domain reset releases, minimum 1.
REQ-006 SHALL have parameter CNT_W, default 8: width of the event counters.
REQ-007 SHALL have port clki, input, 1: the single clock; reset is asynchronous and active-high.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port locked, input, 1: PLL LOCK, asynchronous to clki.
REQ-010 SHALL have port pll_rst, output, 1: drives the PLL RST pin, active-high.
REQ-011 SHALL have port domain_rst, output, NUM_DOMAINS: per-domain active-high resets.
REQ-012 SHALL have port ready, output, 1: high only in RUN.
REQ-013 SHALL have port lock_loss_count, output, CNT_W: saturating count of lock losses in RELEASE or RUN.
REQ-014 SHALL have port retry_count, output, CNT_W: saturating count of timeout retries; tied to 0 when the retry feature is compiled out.

Function
REQ-015 SHALL synchronise locked through two flops, reset to 0, into locked_s; all decisions use locked_s only, giving 2 cycles of input latency.
REQ-016 SHALL implement states PLL_RESET, WAIT_LOCK, FILTER, RELEASE, RUN, with every output registered.
REQ-017 PLL_RESET: pll_rst=1 and all domain_rst=1 for exactly PLLRST_CYCLES cycles, then -> WAIT_LOCK with pll_rst=0.
REQ-018 WAIT_LOCK: on locked_s=1 -> FILTER with the filter counter cleared; otherwise the timeout counter increments.
REQ-019 FILTER: locked_s=0 on any cycle -> WAIT_LOCK with both counters cleared; after LOCK_FILTER consecutive high cycles -> RELEASE.
REQ-020 RELEASE: domain_rst[i] deasserts exactly i*STAGGER cycles after RELEASE entry, in ascending order; a released bit stays 0.
REQ-021 SHALL enter RUN and assert ready=1 on the cycle after domain_rst[NUM_DOMAINS-1] deasserts.
REQ-022 If locked_s=0 in RELEASE or RUN: on the next edge all domain_rst=1, ready=0, lock_loss_count +1 saturating at 2^CNT_W-1, and the state goes to PLL_RESET.
REQ-023 If lock is lost and a counter or release step would occur on the same edge, lock loss wins.
REQ-024 With NUM_DOMAINS=1, domain_rst[0] deasserts on the first RELEASE cycle and RUN follows one cycle later.
REQ-025 Counters SHALL be sized by $clog2 of their limit and SHALL never wrap.

Reset
REQ-026 While rst=1, asynchronously: state=PLL_RESET with its cycle counter at 0, pll_rst=1, domain_rst all 1, ready=0, both counts 0, and synchroniser flops 0.
REQ-027 Reset asserted mid-RELEASE or mid-RUN SHALL immediately reassert every domain_rst; after rst falls, a full PLL_RESET pulse is issued.

Configuration
REQ-028 With macro PLL_SUP_RETRY_EN defined, WAIT_LOCK reaching LOCK_TIMEOUT cycles SHALL go to PLL_RESET and increment retry_count (saturating).
REQ-029 With PLL_SUP_RETRY_EN undefined, WAIT_LOCK SHALL wait indefinitely, the timeout counter SHALL be omitted, and retry_count SHALL be 0.

Verification (NUM_DOMAINS=3, PLLRST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, STAGGER=3, CNT_W=4)
REQ-030 Normal start: release rst, raise locked after 10 cycles -> pll_rst high 4 cycles; domain_rst[0..2] fall 0, 3 and 6 cycles after RELEASE entry; ready rises 1 cycle after domain_rst[2] falls.
REQ-031 Filter glitch: locked drops for 1 cycle after 5 high cycles -> return to WAIT_LOCK; ready rises only after 8 further uninterrupted cycles plus the release sequence.
REQ-032 Loss in RUN: drop locked -> 3 cycles later domain_rst=3'b111, ready=0, lock_loss_count=1, pll_rst pulses high for 4 cycles.
REQ-033 Retry (macro defined): hold locked=0 -> a new 4-cycle pll_rst pulse every 36 cycles; retry_count reaches 15 and saturates at 15. With the macro undefined, no second pulse occurs and retry_count stays 0.
REQ-034 Async reset: assert rst mid-RELEASE between clki edges -> domain_rst=3'b111 and pll_rst=1 before the next edge.
REQ-035 Saturation: cause 20 lock losses -> lock_loss_count holds at 15.
